feather_weight_loader: RTL

- Upstream feeder for a chain of feather PEs.
- Accepts a valid/ready weight stream from the on-chip weight buffer and serialises it into the PE chain's weight bus: o_weights, o_weights_valid, o_pe_sel, o_weights_ping_pong_sel, o_weights_to_use.
- Fills the idle ping-pong bank of every PE while compute reads the other bank.
- Commits the filled bank on a tile-boundary swap command.

---
 rtl/feather_wl_pkg.sv | 26 ++
 rtl/feather_wl_addr_cntr.sv | 73 +++++++
 rtl/feather_weight_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/feather_wl_pkg.sv
// -----------------------------------------------------------------------------
// feather_wl_pkg
//
// Purpose:
//    Shared definitions for the feather weight loader: the loader FSM state
//    encoding and a helper returning the number of weight words that make up
//    one full ping-pong bank across the whole PE chain.
//
// Contents:
//    wl_state_t      - loader FSM states (WL_IDLE, WL_LOAD, WL_FULL)
//    wl_total_words  - NUM_PE * WEIGHTS_DEPTH, words per complete bank load
// -----------------------------------------------------------------------------
package feather_wl_pkg;

   typedef enum logic [1:0] {
      WL_IDLE = 2'd0,
      WL_LOAD = 2'd1,
      WL_FULL = 2'd2
   } wl_state_t;

   // Total words streamed into the chain for one bank load.
   function automatic int wl_total_words(input int num_pe, input int depth);
      return num_pe * depth;
   endfunction

endpackage

// File: rtl/feather_wl_addr_cntr.sv
// -----------------------------------------------------------------------------
// feather_wl_addr_cntr
//
// Purpose:
//    Nested address counter for the weight loader. word_cnt walks the words of
//    one PE bank and, when it wraps, pe_cnt advances to the next PE. last_word
//    flags the final word of the final PE so the loader knows the current
//    transfer completes the bank.
//
// Ports:
//    clk        in   clock
//    rst        in   synchronous active-high reset
//    clear      in   return both counters to zero (priority over incr)
//    incr       in   advance by one word
//    pe_cnt     out  PE index of the current word
//    word_cnt   out  word index within the current PE
//    last_word  out  current position is the last word of the last PE
// -----------------------------------------------------------------------------
module feather_wl_addr_cntr
   import feather_wl_pkg::*;
#(
   parameter int NUM_PE             = 4,
   parameter int WEIGHTS_DEPTH      = 4,
   parameter int LOG2_WEIGHTS_DEPTH = 2,
   parameter int PE_SEL_WIDTH       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          incr,
   output logic [PE_SEL_WIDTH-1:0]       pe_cnt,
   output logic [LOG2_WEIGHTS_DEPTH-1:0] word_cnt,
   output logic                          last_word
);

   localparam int ADDR_WIDTH  = PE_SEL_WIDTH + LOG2_WEIGHTS_DEPTH;
   localparam int TOTAL_WORDS = wl_total_words(NUM_PE, WEIGHTS_DEPTH);

   localparam logic [LOG2_WEIGHTS_DEPTH-1:0] LAST_WORD_IDX =
      LOG2_WEIGHTS_DEPTH'(WEIGHTS_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_FLAT_ADDR =
      ADDR_WIDTH'(TOTAL_WORDS - 1);

   logic [ADDR_WIDTH-1:0] flat_addr;

   // Because WEIGHTS_DEPTH is a power of two, concatenating the PE and word
   // indices gives the flat word number pe*DEPTH+word, so the end of the
   // whole bank is a single compare against the total word count.
   assign flat_addr = {pe_cnt, word_cnt};
   assign last_word = (flat_addr == LAST_FLAT_ADDR);

   // Word counter wraps after each PE's bank; the PE counter steps on that
   // wrap and goes back to zero after the last PE so a finished load leaves
   // the counters ready for the next one.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         pe_cnt   <= '0;
         word_cnt <= '0;
      end else if (incr) begin
         if (word_cnt == LAST_WORD_IDX) begin
            word_cnt <= '0;
            if (last_word) begin
               pe_cnt <= '0;
            end else begin
               pe_cnt <= pe_cnt + 1'b1;
            end
         end else begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/feather_weight_loader.sv
// -----------------------------------------------------------------------------
// feather_weight_loader
//
// Purpose:
//    Upstream feeder for a chain of feather PEs. Takes a valid/ready weight
//    stream from the weight buffer and serialises it onto the PE chain weight
//    bus, filling the idle ping-pong bank of every PE (PE 0 first, words 0 up
//    within each PE) while compute keeps reading the other bank. A swap
//    command at a tile boundary commits the freshly filled bank.
//
// Configuration:
//    FEATHER_WL_ABORT_EN - when defined, adds i_abort, which drops an
//                          in-progress load back to IDLE.
//
// Ports:
//    clk                      in   clock
//    rst                      in   synchronous active-high reset
//    i_start                  in   begin a bank load (IDLE only)
//    i_weights_to_use         in   last weight index for the tile being loaded
//    i_swap                   in   commit the loaded bank (FULL only)
//    i_abort                  in   abandon the current load (option only)
//    i_wt_data                in   source weight word
//    i_wt_valid               in   source word valid
//    o_wt_ready               out  loader accepts a word (high in LOAD)
//    o_weights                out  weight word to PE0
//    o_weights_valid          out  weight word valid to PE0
//    o_pe_sel                 out  destination PE id of o_weights
//    o_weights_ping_pong_sel  out  bank currently being written
//    o_weights_to_use         out  last weight index for the compute bank
//    o_busy                   out  high in LOAD
//    o_done                   out  one-cycle pulse with the final weight word
//    o_bank_full              out  high in FULL
// -----------------------------------------------------------------------------
module feather_weight_loader
   import feather_wl_pkg::*;
#(
   parameter int NUM_PE             = 4,
   parameter int WEIGHTS_DATA_WIDTH = 8,
   parameter int WEIGHTS_DEPTH      = 4,
   parameter int LOG2_WEIGHTS_DEPTH = 2,
   parameter int PE_SEL_WIDTH       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic [LOG2_WEIGHTS_DEPTH-1:0] i_weights_to_use,
   input  logic                          i_swap,
`ifdef FEATHER_WL_ABORT_EN
   input  logic                          i_abort,
`endif
   input  logic [WEIGHTS_DATA_WIDTH-1:0] i_wt_data,
   input  logic                          i_wt_valid,
   output logic                          o_wt_ready,
   output logic [WEIGHTS_DATA_WIDTH-1:0] o_weights,
   output logic                          o_weights_valid,
   output logic [PE_SEL_WIDTH-1:0]       o_pe_sel,
   output logic                          o_weights_ping_pong_sel,
   output logic [LOG2_WEIGHTS_DEPTH-1:0] o_weights_to_use,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_bank_full
);

   wl_state_t                       state;
   logic [LOG2_WEIGHTS_DEPTH-1:0]   r_pending_to_use;
   logic                            transfer;
   logic                            abort_req;
   logic                            cnt_clear;
   logic [PE_SEL_WIDTH-1:0]         pe_cnt;
   logic [LOG2_WEIGHTS_DEPTH-1:0]   word_cnt;
   logic                            last_word;

   // The abort request collapses to a constant zero when the option is not
   // built, leaving completion or reset as the only ways out of LOAD.
`ifdef FEATHER_WL_ABORT_EN
   assign abort_req = i_abort;
`else
   assign abort_req = 1'b0;
`endif

   // o_wt_ready is registered and is high exactly while in LOAD, so it can
   // qualify the handshake directly. Counters are held at zero whenever the
   // loader is idle and are also wiped by an abort so the next load starts
   // at PE 0, word 0.
   assign transfer  = i_wt_valid & o_wt_ready;
   assign cnt_clear = (state == WL_IDLE) | ((state == WL_LOAD) & abort_req);

   feather_wl_addr_cntr #(
      .NUM_PE             (NUM_PE),
      .WEIGHTS_DEPTH      (WEIGHTS_DEPTH),
      .LOG2_WEIGHTS_DEPTH (LOG2_WEIGHTS_DEPTH),
      .PE_SEL_WIDTH       (PE_SEL_WIDTH)
   ) u_addr_cntr (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .incr      (transfer),
      .pe_cnt    (pe_cnt),
      .word_cnt  (word_cnt),
      .last_word (last_word)
   );

   // Loader FSM with all outputs registered alongside it. Every accepted word
   // is forwarded one cycle later tagged with its PE id; without a transfer
   // the data and PE id hold and only the valid drops. The ping-pong select
   // and compute-side to_use only move on an accepted swap, so the PEs keep
   // computing from the other bank for the whole load. word_cnt is not needed
   // here because the bank end is already folded into last_word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= WL_IDLE;
         r_pending_to_use        <= '0;
         o_wt_ready              <= 1'b0;
         o_weights               <= '0;
         o_weights_valid         <= 1'b0;
         o_pe_sel                <= '0;
         o_weights_ping_pong_sel <= 1'b0;
         o_weights_to_use        <= '0;
         o_busy                  <= 1'b0;
         o_done                  <= 1'b0;
         o_bank_full             <= 1'b0;
      end else begin
         o_weights_valid <= transfer;
         o_done          <= 1'b0;
         if (transfer) begin
            o_weights <= i_wt_data;
            o_pe_sel  <= pe_cnt;
         end

         case (state)
            WL_IDLE: begin
               if (i_start) begin
                  state            <= WL_LOAD;
                  r_pending_to_use <= i_weights_to_use;
                  o_wt_ready       <= 1'b1;
                  o_busy           <= 1'b1;
               end
            end

            WL_LOAD: begin
               if (abort_req) begin
                  state      <= WL_IDLE;
                  o_wt_ready <= 1'b0;
                  o_busy     <= 1'b0;
               end else if (transfer && last_word) begin
                  state       <= WL_FULL;
                  o_wt_ready  <= 1'b0;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
                  o_bank_full <= 1'b1;
               end
            end

            WL_FULL: begin
               if (i_swap) begin
                  state                   <= WL_IDLE;
                  o_weights_ping_pong_sel <= ~o_weights_ping_pong_sel;
                  o_weights_to_use        <= r_pending_to_use;
                  o_bank_full             <= 1'b0;
               end
            end

            default: begin
               state       <= WL_IDLE;
               o_wt_ready  <= 1'b0;
               o_busy      <= 1'b0;
               o_bank_full <= 1'b0;
            end
         endcase
      end
   end

   logic unused_word_cnt;
   assign unused_word_cnt = ^word_cnt;

endmodule
